// File: rtl/mdr_ram_alu_if.sv
// Datapath-side bundle for mdr_ram_alu: MDR/RAM control, ALU operands and results.
interface mdr_ram_alu_if #(
  parameter int ADDR_W = 9
);
  logic              mdr_in;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       bus_in;
  logic [31:0]       y_in;
  logic [4:0]        opcode;
  logic              inc_pc;
  logic              branch_flag;
  logic [31:0]       mdr_out;
  logic [31:0]       ram_out;
  logic [31:0]       c_hi;
  logic [31:0]       c_lo;

  modport master (
    output mdr_in, read, write, addr, bus_in, y_in, opcode, inc_pc, branch_flag,
    input  mdr_out, ram_out, c_hi, c_lo
  );

  modport slave (
    input  mdr_in, read, write, addr, bus_in, y_in, opcode, inc_pc, branch_flag,
    output mdr_out, ram_out, c_hi, c_lo
  );
endinterface

// File: rtl/mdr_ram_alu.sv
// MDR + 2**ADDR_W x 32 async-read RAM + combinational 32-bit ALU; MDR/RAM write 1 cycle, ALU 0 cycles.
// No backpressure: loads and writes take effect on the enabling edge; RAM starts all zeros.
module mdr_ram_alu #(
  parameter int ADDR_W = 9,
  parameter INIT_FILE = "ram_init.hex"
) (
  input  logic         clk,
  input  logic         clr,
  mdr_ram_alu_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_SHR  = 5'b00111, OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001, OP_ROR  = 5'b01010, OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001;

  // ---------------- MDR and RAM ----------------
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [31:0] mdr_q, mdr_d;
  logic [31:0] ram_rd;

  assign ram_rd = mem[bus.addr];

  always_comb begin
    mdr_d = mdr_q;
    if (bus.mdr_in) begin
      mdr_d = bus.read ? ram_rd : bus.bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      mdr_q <= '0;
    end else begin
      mdr_q <= mdr_d;
    end
  end

  // RAM contents survive clr; write data is the MDR value before this edge.
  always_ff @(posedge clk) begin
    if (bus.write) begin
      mem[bus.addr] <= mdr_q;
    end
  end

  assign bus.mdr_out = mdr_q;
  assign bus.ram_out = ram_rd;

  // ---------------- ALU ----------------
  logic [31:0]        a, b;
  logic [4:0]         sh;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;
  logic [63:0]        rot_r, rot_l;
  logic [31:0]        alu_hi, alu_lo;

  assign a     = bus.y_in;
  assign b     = bus.bus_in;
  assign sh    = b[4:0];
  assign prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quo   = (b == 32'd0) ? 32'sd0 : $signed(a) / $signed(b);
  assign rem   = (b == 32'd0) ? 32'sd0 : $signed(a) % $signed(b);
  // Rotating a doubled word makes a zero count fall out naturally as A.
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    if (bus.inc_pc) begin
      alu_lo = b + 32'd1;
    end else begin
      unique case (bus.opcode)
        OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_lo = a + b;
        OP_SUB:           alu_lo = a - b;
        OP_AND, OP_ANDI:  alu_lo = a & b;
        OP_OR, OP_ORI:    alu_lo = a | b;
        OP_SHR:           alu_lo = a >> sh;
        OP_SHRA:          alu_lo = $unsigned($signed(a) >>> sh);
        OP_SHL:           alu_lo = a << sh;
        OP_ROR:           alu_lo = rot_r[31:0];
        OP_ROL:           alu_lo = rot_l[63:32];
        OP_MUL: begin
          alu_hi = prod[63:32];
          alu_lo = prod[31:0];
        end
        OP_DIV: begin
          if (b == 32'd0) begin
            alu_hi = a;
            alu_lo = 32'hFFFF_FFFF;
          end else begin
            alu_hi = rem;
            alu_lo = quo;
          end
        end
        OP_NEG:           alu_lo = 32'd0 - b;
        OP_NOT:           alu_lo = ~b;
        OP_BR:            alu_lo = bus.branch_flag ? a + b : a;
        OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: alu_lo = b;
        default: begin
          alu_hi = '0;
          alu_lo = '0;
        end
      endcase
    end
  end

  assign bus.c_hi = alu_hi;
  assign bus.c_lo = alu_lo;
endmodule

// File: tb/tb_mdr_ram_alu.sv
// Directed + randomized bench for mdr_ram_alu against an arithmetic reference model.
module tb_mdr_ram_alu;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mdr_ram_alu_if #(.ADDR_W(AW)) bif();

  mdr_ram_alu #(.ADDR_W(AW)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bif)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [512];
  logic [31:0] mdr_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU built on 64-bit signed integer arithmetic.
  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic inc, input logic bf,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int n = int'(b[4:0]);
    longint p;
    logic [31:0] hi = 32'd0;
    logic [31:0] lo = 32'd0;
    if (inc) begin
      lo = b + 32'd1;
    end else begin
      case (int'(op))
        0, 1, 2, 3, 12: lo = a + b;
        4:  lo = a - b;
        5, 13: lo = a & b;
        6, 14: lo = a | b;
        7:  lo = a >> n;
        8: begin p = sa >>> n; lo = p[31:0]; end
        9:  lo = a << n;
        10: lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
        11: lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
        15: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
        16: begin
          if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
          end else begin
            p = sa / sb; lo = p[31:0];
            p = sa % sb; hi = p[31:0];
          end
        end
        17: lo = -b;
        18: lo = ~b;
        19: lo = bf ? a + b : a;
        20, 21, 22, 23, 24, 25: lo = b;
        default: begin hi = 32'd0; lo = 32'd0; end
      endcase
    end
    return {hi, lo};
  endfunction

  task automatic drive_alu(input logic [4:0] op, input logic inc, input logic bf,
                           input logic [31:0] a, input logic [31:0] b);
    bif.opcode      = op;
    bif.inc_pc      = inc;
    bif.branch_flag = bf;
    bif.y_in        = a;
    bif.bus_in      = b;
    #1;
  endtask

  task automatic alu_const(input string tag, input logic [4:0] op, input logic inc, input logic bf,
                           input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    drive_alu(op, inc, bf, a, b);
    check(tag, {bif.c_hi, bif.c_lo}, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem_m[i] = 32'd0;

    clr             = 1'b1;
    bif.mdr_in      = 1'b1;
    bif.read        = 1'b0;
    bif.write       = 1'b0;
    bif.addr        = 9'h055;
    bif.bus_in      = 32'hDEAD_BEEF;
    bif.y_in        = 32'd0;
    bif.opcode      = 5'b11010;
    bif.inc_pc      = 1'b0;
    bif.branch_flag = 1'b0;

    // Reset and directed MDR/RAM sequence
    tick();
    check("reset_mdr", {32'd0, bif.mdr_out}, 64'd0);
    check("reset_ram55", {32'd0, bif.ram_out}, 64'd0);

    clr        = 1'b0;
    bif.bus_in = 32'h1234_5678;
    tick();
    check("mdr_from_bus", {32'd0, bif.mdr_out}, 64'h1234_5678);

    bif.mdr_in = 1'b0;
    bif.write  = 1'b1;
    #1;
    check("ram_old_before_write", {32'd0, bif.ram_out}, 64'd0);
    tick();
    check("ram_after_write", {32'd0, bif.ram_out}, 64'h1234_5678);

    bif.write  = 1'b0;
    clr        = 1'b1;
    bif.mdr_in = 1'b1;
    bif.bus_in = 32'h0000_FFFF;
    tick();
    check("clr_mdr", {32'd0, bif.mdr_out}, 64'd0);
    check("clr_keeps_ram", {32'd0, bif.ram_out}, 64'h1234_5678);

    clr      = 1'b0;
    bif.read = 1'b1;
    tick();
    check("mdr_from_ram", {32'd0, bif.mdr_out}, 64'h1234_5678);
    mdr_m          = 32'h1234_5678;
    mem_m[9'h055]  = 32'h1234_5678;

    // Randomized MDR/RAM traffic over a small address window
    for (int i = 0; i < 60; i++) begin
      logic          r_clr, r_in, r_rd, r_wr;
      logic [8:0]    r_addr;
      logic [31:0]   r_bus, nxt;
      r_clr  = ($urandom_range(0, 9) == 0);
      r_in   = 1'($urandom_range(0, 1));
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 9'h050 + 9'($urandom_range(0, 15));
      r_bus  = $urandom;
      clr        = r_clr;
      bif.mdr_in = r_in;
      bif.read   = r_rd;
      bif.write  = r_wr;
      bif.addr   = r_addr;
      bif.bus_in = r_bus;
      #1;
      check("rand_ram_read", {32'd0, bif.ram_out}, {32'd0, mem_m[r_addr]});
      if (r_clr)     nxt = 32'd0;
      else if (r_in) nxt = r_rd ? mem_m[r_addr] : r_bus;
      else           nxt = mdr_m;
      if (r_wr) mem_m[r_addr] = mdr_m;
      mdr_m = nxt;
      tick();
      check("rand_mdr", {32'd0, bif.mdr_out}, {32'd0, mdr_m});
    end
    clr       = 1'b0;
    bif.write = 1'b0;
    bif.mdr_in = 1'b0;

    // Directed ALU vectors with hand-derived results
    alu_const("div_neg7_2",   5'b10000, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    alu_const("mul_min_2",    5'b01111, 1'b0, 1'b0, 32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000);
    alu_const("ror_1",        5'b01010, 1'b0, 1'b0, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    alu_const("shra_1",       5'b01000, 1'b0, 1'b0, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    alu_const("shr_1",        5'b00111, 1'b0, 1'b0, 32'h8000_0001, 32'd1, 64'h0000_0000_4000_0000);
    alu_const("br_taken",     5'b10011, 1'b0, 1'b1, 32'd100, 32'd20, 64'd120);
    alu_const("br_not_taken", 5'b10011, 1'b0, 1'b0, 32'd100, 32'd20, 64'd100);
    alu_const("inc_pc_mul",   5'b01111, 1'b1, 1'b0, 32'h8000_0000, 32'd100, 64'd101);
    alu_const("inc_pc_div",   5'b10000, 1'b1, 1'b1, 32'd7, 32'd100, 64'd101);
    alu_const("div_by_zero",  5'b10000, 1'b0, 1'b0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
    alu_const("rol_zero_cnt", 5'b01011, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'd32, 64'h0000_0000_A5A5_0F0F);
    alu_const("ror_zero_cnt", 5'b01010, 1'b0, 1'b0, 32'h8000_0001, 32'd64, 64'h0000_0000_8000_0001);
    alu_const("halt_zero",    5'b11011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    alu_const("unlisted",     5'b11111, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    alu_const("neg",          5'b10001, 1'b0, 1'b0, 32'd0, 32'd5, 64'h0000_0000_FFFF_FFFB);
    alu_const("add_wrap",     5'b00011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'd1);

    // Randomized ALU against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  r_op;
      logic        r_inc, r_bf;
      logic [31:0] r_a, r_b;
      r_op  = 5'($urandom_range(0, 31));
      r_inc = ($urandom_range(0, 7) == 0);
      r_bf  = 1'($urandom_range(0, 1));
      r_a   = $urandom;
      r_b   = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
      if (r_op == 5'b10000 && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd3;
      drive_alu(r_op, r_inc, r_bf, r_a, r_b);
      check($sformatf("rand_alu_op%0d", r_op), {bif.c_hi, bif.c_lo},
            alu_ref(r_op, r_inc, r_bf, r_a, r_b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
